// File: rtl/frame_crc_checker.sv
// frame_crc_checker: observes the PPU pixel stream, runs a reflected CRC-32
// over every visible pixel of a frame, and publishes a per-frame signature
// record (CRC, pixel count, size check, final pixel position) on a one-cycle
// frame_valid pulse after the vblank rising edge that closes the frame.
//
// Interface semantics: there is no handshake. pixel is qualified only by
// pixel_en; the block never stalls the source, and frame_valid is a
// single-cycle strobe with the record outputs holding until the next strobe.
module frame_crc_checker #(
    parameter int unsigned WIDTH       = 256,
    parameter int unsigned HEIGHT      = 240,
    parameter int unsigned SKIP_FRAMES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pixel,
    input  logic        pixel_en,
    input  logic        vblank,
    output logic        synced,
    output logic        frame_valid,
    output logic [31:0] frame_crc,
    output logic [15:0] frame_num,
    output logic [17:0] pix_count,
    output logic        size_err,
    output logic [8:0]  last_x,
    output logic [8:0]  last_y
);

    localparam logic [31:0] POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;
    localparam logic [17:0] CNT_MAX   = 18'h3FFFF;
    localparam logic [17:0] FRAME_PIX = 18'(WIDTH * HEIGHT);
    localparam logic [8:0]  X_MAX     = 9'(WIDTH - 1);
    localparam logic [8:0]  Y_MAX     = 9'd511;
    localparam logic [15:0] SKIP_INIT = 16'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    // state is kept as a named enum so checkers can bind to it directly.
    state_t state, state_next;

    logic        vb_q;
    logic        rise, fall;
    logic        start, publish, skip_dec, take;
    logic [31:0] crc_q, base_crc, nxt_crc;
    logic [17:0] cnt_q, base_cnt, nxt_cnt;
    logic [8:0]  x_q, base_x, nxt_x;
    logic [8:0]  y_q, base_y, nxt_y;
    logic [8:0]  lx_q, base_lx, nxt_lx;
    logic [8:0]  ly_q, base_ly, nxt_ly;
    logic [15:0] skip_q;
    logic [15:0] num_q;

    // One byte of reflected CRC-32, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign rise = vblank & ~vb_q;
    assign fall = ~vblank & vb_q;

    // FSM register plus the single vblank delay used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNSYNC;
            vb_q  <= 1'b0;
        end else begin
            state <= state_next;
            vb_q  <= vblank;
        end
    end

    // Next state and frame boundary decisions (start, publish, skip).
    always_comb begin
        state_next = state;
        start      = 1'b0;
        publish    = 1'b0;
        skip_dec   = 1'b0;
        case (state)
            UNSYNC: begin
                if (fall) begin
                    start      = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (rise) begin
                    state_next = BLANK;
                    if (skip_q != 16'd0) skip_dec = 1'b1;
                    else                 publish  = 1'b1;
                end
            end
            BLANK: begin
                if (fall) begin
                    start      = 1'b1;
                    state_next = ACTIVE;
                end
            end
            default: state_next = UNSYNC;
        endcase
    end

    // Running frame datapath: a frame start clears first, then the pixel of
    // the same cycle (if any) is folded in, so fall- and rise-coincident
    // pixels both land in the right frame.
    always_comb begin
        take     = pixel_en && ((state == ACTIVE) || start);
        base_crc = start ? CRC_INIT : crc_q;
        base_cnt = start ? 18'd0 : cnt_q;
        base_x   = start ? 9'd0 : x_q;
        base_y   = start ? 9'd0 : y_q;
        base_lx  = start ? 9'd0 : lx_q;
        base_ly  = start ? 9'd0 : ly_q;
        nxt_crc  = base_crc;
        nxt_cnt  = base_cnt;
        nxt_x    = base_x;
        nxt_y    = base_y;
        nxt_lx   = base_lx;
        nxt_ly   = base_ly;
        if (take) begin
            nxt_crc = crc_byte(base_crc, pixel);
            nxt_cnt = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + 18'd1;
            nxt_lx  = base_x;
            nxt_ly  = base_y;
            if (base_x == X_MAX) begin
                nxt_x = 9'd0;
                nxt_y = (base_y == Y_MAX) ? Y_MAX : base_y + 9'd1;
            end else begin
                nxt_x = base_x + 9'd1;
            end
        end
    end

    // Running CRC, count and position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
            cnt_q <= 18'd0;
            x_q   <= 9'd0;
            y_q   <= 9'd0;
            lx_q  <= 9'd0;
            ly_q  <= 9'd0;
        end else begin
            crc_q <= nxt_crc;
            cnt_q <= nxt_cnt;
            x_q   <= nxt_x;
            y_q   <= nxt_y;
            lx_q  <= nxt_lx;
            ly_q  <= nxt_ly;
        end
    end

    // Published record, frame index and post-sync skip counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synced      <= 1'b0;
            frame_valid <= 1'b0;
            frame_crc   <= 32'd0;
            frame_num   <= 16'd0;
            pix_count   <= 18'd0;
            size_err    <= 1'b0;
            last_x      <= 9'd0;
            last_y      <= 9'd0;
            skip_q      <= SKIP_INIT;
            num_q       <= 16'd0;
        end else begin
            frame_valid <= publish;
            if (start) synced <= 1'b1;
            if (skip_dec) skip_q <= skip_q - 16'd1;
            if (publish) begin
                frame_crc <= nxt_crc ^ CRC_INIT;
                pix_count <= nxt_cnt;
                size_err  <= (nxt_cnt != FRAME_PIX);
                last_x    <= nxt_lx;
                last_y    <= nxt_ly;
                frame_num <= num_q;
                num_q     <= num_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_crc_checker.sv
// Directed bench for frame_crc_checker. Five instances share one stimulus
// stream: [0] 9x1, [1] 1x1, [2] defaults 256x240, [3] 256x2, [4] 9x1 with
// two skipped frames. Each step checks only the instance it targets.
module tb_frame_crc_checker;

    localparam logic [31:0] CRC_DIGITS = 32'hCBF43926;  // "123456789"
    localparam logic [31:0] CRC_ZERO1  = 32'hD202EF8D;  // single 0x00

    // clock/reset block
    logic clk;
    logic rst_n;
    logic [7:0] pixel;
    logic pixel_en;
    logic vblank;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        syn  [5];
    logic        fv   [5];
    logic [31:0] crc  [5];
    logic [15:0] num  [5];
    logic [17:0] pc   [5];
    logic        serr [5];
    logic [8:0]  lx   [5];
    logic [8:0]  ly   [5];

    int checks = 0;
    int errors = 0;
    int pulses [5] = '{default: 0};
    int dbl = 0;
    logic prev_fv [5] = '{default: 1'b0};

    frame_crc_checker #(.WIDTH(9), .HEIGHT(1), .SKIP_FRAMES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .pixel(pixel), .pixel_en(pixel_en), .vblank(vblank),
        .synced(syn[0]), .frame_valid(fv[0]), .frame_crc(crc[0]), .frame_num(num[0]),
        .pix_count(pc[0]), .size_err(serr[0]), .last_x(lx[0]), .last_y(ly[0]));
    frame_crc_checker #(.WIDTH(1), .HEIGHT(1), .SKIP_FRAMES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .pixel(pixel), .pixel_en(pixel_en), .vblank(vblank),
        .synced(syn[1]), .frame_valid(fv[1]), .frame_crc(crc[1]), .frame_num(num[1]),
        .pix_count(pc[1]), .size_err(serr[1]), .last_x(lx[1]), .last_y(ly[1]));
    frame_crc_checker u2 (
        .clk(clk), .rst_n(rst_n), .pixel(pixel), .pixel_en(pixel_en), .vblank(vblank),
        .synced(syn[2]), .frame_valid(fv[2]), .frame_crc(crc[2]), .frame_num(num[2]),
        .pix_count(pc[2]), .size_err(serr[2]), .last_x(lx[2]), .last_y(ly[2]));
    frame_crc_checker #(.WIDTH(256), .HEIGHT(2), .SKIP_FRAMES(0)) u3 (
        .clk(clk), .rst_n(rst_n), .pixel(pixel), .pixel_en(pixel_en), .vblank(vblank),
        .synced(syn[3]), .frame_valid(fv[3]), .frame_crc(crc[3]), .frame_num(num[3]),
        .pix_count(pc[3]), .size_err(serr[3]), .last_x(lx[3]), .last_y(ly[3]));
    frame_crc_checker #(.WIDTH(9), .HEIGHT(1), .SKIP_FRAMES(2)) u4 (
        .clk(clk), .rst_n(rst_n), .pixel(pixel), .pixel_en(pixel_en), .vblank(vblank),
        .synced(syn[4]), .frame_valid(fv[4]), .frame_crc(crc[4]), .frame_num(num[4]),
        .pix_count(pc[4]), .size_err(serr[4]), .last_x(lx[4]), .last_y(ly[4]));

    // pulse monitor: counts frame_valid pulses and back-to-back highs
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (fv[k]) pulses[k] = pulses[k] + 1;
            if (fv[k] && prev_fv[k]) dbl = dbl + 1;
            prev_fv[k] = fv[k];
        end
    end

    // scoreboard check
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix_of(input int i, input bit zero);
        return zero ? 8'h00 : 8'(32'h31 + 32'(i % 9));
    endfunction

    // One frame: fall, n pixels, rise. jf puts pixel 0 on the fall cycle,
    // jr puts the last pixel on the rise cycle. Returns one cycle after the
    // rise edge, where the record pulse is expected.
    task automatic frame(input int n, input bit zero, input bit jf, input bit jr);
        int i;
        i = 0;
        vblank = 1'b0;
        if (jf && n > 0) begin
            pixel = pix_of(0, zero);
            pixel_en = 1'b1;
            i = 1;
        end else begin
            pixel_en = 1'b0;
        end
        tick();
        while (i < n - (jr ? 1 : 0)) begin
            pixel = pix_of(i, zero);
            pixel_en = 1'b1;
            tick();
            i++;
        end
        vblank = 1'b1;
        if (jr && i < n) begin
            pixel = pix_of(i, zero);
            pixel_en = 1'b1;
        end else begin
            pixel_en = 1'b0;
        end
        tick();
        pixel_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pixel_en = 1'b0;
        vblank = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_zero(input string tag, input int k);
        chk({tag, "_synced"}, 32'(syn[k]), 0);
        chk({tag, "_valid"},  32'(fv[k]),  0);
        chk({tag, "_crc"},    crc[k],      0);
        chk({tag, "_num"},    32'(num[k]), 0);
        chk({tag, "_count"},  32'(pc[k]),  0);
        chk({tag, "_serr"},   32'(serr[k]), 0);
        chk({tag, "_lx"},     32'(lx[k]),  0);
        chk({tag, "_ly"},     32'(ly[k]),  0);
    endtask

    // directed sequence
    initial begin
        rst_n = 1'b0;
        vblank = 1'b1;
        pixel_en = 1'b0;
        pixel = 8'h00;
        tick();
        tick();
        chk_zero("reset", 0);

        // vblank high at release; pixels before the first fall are ignored
        rst_n = 1'b1;
        pixel_en = 1'b1;
        pixel = 8'hA5;
        tick(); tick(); tick();
        pixel_en = 1'b0;
        tick();
        chk("unsync_synced", 32'(syn[0]), 0);
        chk("unsync_pulses", 32'(pulses[0]), 0);

        // "123456789" on 9x1
        frame(9, 1'b0, 1'b0, 1'b0);
        chk("f1_valid",  32'(fv[0]),  1);
        chk("f1_crc",    crc[0],      CRC_DIGITS);
        chk("f1_count",  32'(pc[0]),  9);
        chk("f1_serr",   32'(serr[0]), 0);
        chk("f1_lx",     32'(lx[0]),  8);
        chk("f1_ly",     32'(ly[0]),  0);
        chk("f1_num",    32'(num[0]), 0);
        chk("f1_synced", 32'(syn[0]), 1);
        chk("f1_skip_valid", 32'(fv[4]), 0);
        chk("f1_w1_ly",   32'(ly[1]), 8);
        chk("f1_w1_lx",   32'(lx[1]), 0);
        chk("f1_w1_serr", 32'(serr[1]), 1);
        chk("f1_def_serr", 32'(serr[2]), 1);
        chk("f1_def_lx",   32'(lx[2]), 8);
        tick();
        chk("f1_pulse_end", 32'(fv[0]), 0);
        chk("f1_crc_hold",  crc[0], CRC_DIGITS);

        // last byte coincident with the rise
        frame(9, 1'b0, 1'b0, 1'b1);
        chk("f2_valid", 32'(fv[0]),  1);
        chk("f2_crc",   crc[0],      CRC_DIGITS);
        chk("f2_count", 32'(pc[0]),  9);
        chk("f2_num",   32'(num[0]), 1);
        chk("f2_skip_valid", 32'(fv[4]), 0);
        tick();

        // pixel_en during blanking must not disturb the next frame
        pixel_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pixel = 8'($urandom_range(0, 255));
            tick();
        end
        pixel_en = 1'b0;
        tick();

        // first byte coincident with the fall
        frame(9, 1'b0, 1'b1, 1'b0);
        chk("f3_crc",   crc[0],      CRC_DIGITS);
        chk("f3_count", 32'(pc[0]),  9);
        chk("f3_num",   32'(num[0]), 2);
        chk("f3_skip_valid", 32'(fv[4]), 1);
        chk("f3_skip_num",   32'(num[4]), 0);
        chk("f3_skip_crc",   crc[4], CRC_DIGITS);
        tick();

        // zero-pixel frame
        frame(0, 1'b1, 1'b0, 1'b0);
        chk("f0_valid", 32'(fv[0]),  1);
        chk("f0_crc",   crc[0],      0);
        chk("f0_count", 32'(pc[0]),  0);
        chk("f0_serr",  32'(serr[0]), 1);
        chk("f0_lx",    32'(lx[0]),  0);
        chk("f0_ly",    32'(ly[0]),  0);
        chk("f0_num",   32'(num[0]), 3);
        tick();

        // reset in the middle of a frame
        vblank = 1'b0;
        tick();
        pixel_en = 1'b1;
        pixel = 8'h55;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero("midrst", 0);
        pixel_en = 1'b0;
        vblank = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("resync_synced", 32'(syn[0]), 0);
        frame(9, 1'b0, 1'b0, 1'b0);
        chk("resync_valid", 32'(fv[0]),  1);
        chk("resync_num",   32'(num[0]), 0);
        chk("resync_crc",   crc[0],      CRC_DIGITS);
        tick();

        // single zero pixel on 1x1, twice
        do_reset();
        frame(1, 1'b1, 1'b0, 1'b0);
        chk("w1a_crc",   crc[1],      CRC_ZERO1);
        chk("w1a_num",   32'(num[1]), 0);
        chk("w1a_count", 32'(pc[1]),  1);
        chk("w1a_serr",  32'(serr[1]), 0);
        tick();
        frame(1, 1'b1, 1'b0, 1'b0);
        chk("w1b_crc",   crc[1],      CRC_ZERO1);
        chk("w1b_num",   32'(num[1]), 1);
        tick();

        // line wrap and exact-size boundaries
        do_reset();
        frame(257, 1'b1, 1'b0, 1'b0);
        chk("def_count", 32'(pc[2]), 257);
        chk("def_lx",    32'(lx[2]), 0);
        chk("def_ly",    32'(ly[2]), 1);
        chk("def_serr",  32'(serr[2]), 1);
        tick();
        frame(511, 1'b1, 1'b0, 1'b0);
        chk("h2a_count", 32'(pc[3]), 511);
        chk("h2a_serr",  32'(serr[3]), 1);
        chk("h2a_lx",    32'(lx[3]), 254);
        chk("h2a_ly",    32'(ly[3]), 1);
        tick();
        frame(512, 1'b1, 1'b0, 1'b0);
        chk("h2b_count", 32'(pc[3]), 512);
        chk("h2b_serr",  32'(serr[3]), 0);
        chk("h2b_lx",    32'(lx[3]), 255);
        chk("h2b_ly",    32'(ly[3]), 1);
        chk("h2b_num",   32'(num[3]), 2);
        chk("h2b_skip_valid", 32'(fv[4]), 1);
        tick();
        tick();

        chk("skip_pulses", 32'(pulses[4]), 3);
        chk("double_pulse", 32'(dbl), 0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_crc_checker.md
Name: frame_crc_checker

Overview:
- Sits directly downstream of the NES core's video output, on the PPU pixel clock.
- Consumes the pixel / pixel_en / vblank stream and computes a CRC-32 over every visible pixel of each frame.
- Checks the pixel count against the expected frame size, then publishes a per-frame signature record. Regression benches and the on-board debug path use this record to compare frames without storing them.

Parameters:
- WIDTH, 256, visible pixels per line.
- HEIGHT, 240, visible lines per frame.
- SKIP_FRAMES, 0, number of complete frames discarded after sync before records are published.

Ports:
- clk  in  1  pixel clock (PPU clock); all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pixel  in  8  pixel value; sampled only when pixel_en=1.
- pixel_en  in  1  pixel qualifier.
- vblank  in  1  vertical blank level from the core.
- synced  out  1  high once the first vblank falling edge has been seen.
- frame_valid  out  1  one-cycle pulse; record outputs updated this cycle.
- frame_crc  out  32  CRC-32 of the last completed frame.
- frame_num  out  16  index of the published frame, starting at 0; wraps 0xFFFF->0.
- pix_count  out  18  pixels counted in the last frame; saturates at 0x3FFFF.
- size_err  out  1  last frame's pix_count != WIDTH*HEIGHT.
- last_x  out  9  column of the last pixel in the last frame (pix-1) mod WIDTH.
- last_y  out  9  row of the last pixel, (pix-1)/WIDTH, capped at 511.

Behaviour:
- Reset (async assert, sync release):
  - synced=0, frame_valid=0, frame_crc=0, frame_num=0, pix_count=0, size_err=0, last_x=0, last_y=0.
  - Internal CRC=0xFFFFFFFF; skip counter=SKIP_FRAMES; state=UNSYNC.
- CRC algorithm:
  - Reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - One full byte per cycle when pixel_en=1, computed combinationally from the running register.
- vblank edge detection: vblank is registered once (vb_q).
  - rise = vblank & ~vb_q.
  - fall = ~vblank & vb_q.
- State machine:
  - UNSYNC:
    - Ignore pixels.
    - On fall: synced<=1, clear CRC/counters, go ACTIVE.
  - ACTIVE:
    - Each pixel_en cycle: update CRC, increment count (saturating), advance x (wraps at WIDTH-1 with y+1).
    - On rise: if skip counter>0, decrement it and publish nothing; otherwise publish. Then go BLANK.
  - BLANK:
    - pixel_en cycles are ignored.
    - On fall: clear running CRC/count/x/y, go ACTIVE.
- Publish (registered; outputs valid the cycle after the rise is detected, concurrent with the frame_valid pulse):
  - frame_crc = final CRC, pix_count = count, size_err = (count != WIDTH*HEIGHT), last_x/last_y = position of the final pixel.
  - frame_num holds the published frame's index and increments after each publish.
  - A zero-pixel frame publishes CRC 0x00000000, pix_count 0, last_x=last_y=0, size_err=1.
- Simultaneous events:
  - pixel_en in the same cycle as rise is included in the closing frame.
  - pixel_en in the same cycle as fall is included in the new frame (the clear happens first).
- Record outputs hold between pulses. frame_valid is never high for two consecutive cycles.
- vblank high at reset release: stay UNSYNC until its fall.
- Reset mid-frame discards the partial frame; frame_num restarts at 0.
- No back-pressure: this block is a pure observer and never stalls the source.

Test Plan:
1. WIDTH=9, HEIGHT=1: vblank 1->0, feed ASCII "123456789" (0x31..0x39) one per cycle, vblank 0->1 -> frame_valid one cycle, frame_crc=0xCBF43926, pix_count=9, size_err=0, last_x=8, last_y=0, frame_num=0.
2. WIDTH=1, HEIGHT=1: single pixel 0x00 -> frame_crc=0xD202EF8D. Repeat the frame -> identical CRC, frame_num=1.
3. Defaults: frame of 61439 pixels -> size_err=1, pix_count=61439, last_x=254, last_y=239. Next frame with 61440 pixels -> size_err=0, last_x=255, last_y=239.
4. vblank high at reset release, pixels and a rise before the first fall -> no frame_valid, synced=0 until the fall. SKIP_FRAMES=2 -> first pulse after the third complete frame, frame_num=0.
5. WIDTH=9, HEIGHT=1, "123456789": pixel_en with last byte coincident with the rise -> CRC still 0xCBF43926. pixel_en in BLANK -> ignored, next frame's CRC unaffected.
6. Assert rst_n=0 mid-frame after 3 frames -> all outputs 0 immediately. After re-sync, next record has frame_num=0 and a correct CRC.
